// File: rtl/block_to_raster_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : block_to_raster_if
//  Purpose  : Bundles the block-side input stream, the raster-side output
//             stream and the sticky error flag of block_to_raster.
//  Signals  : in_valid/in_ready/in_data/in_sop/in_eop   - 8x8 block samples
//             out_valid/out_ready/out_data              - raster pixels
//             out_sol/out_eol/out_sof/out_eof           - raster markers
//             err                                       - sticky framing error
//  Modports : master - producer of blocks / consumer of raster (environment)
//             slave  - the converter itself
//  Revision : 1.0 - initial release
// ============================================================================
interface block_to_raster_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sol;
  logic              out_eol;
  logic              out_sof;
  logic              out_eof;
  logic              err;

  modport master (
    output in_valid, in_data, in_sop, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_sol, out_eol, out_sof, out_eof, err
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_sol, out_eol, out_sof, out_eof, err
  );
endinterface
`default_nettype wire

// File: rtl/block_to_raster.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : block_to_raster
//  Purpose  : Converts 8x8 pixel blocks (row-major inside a block, blocks
//             left-to-right across an 8-line band) into raster-order pixels.
//             Two 8-line banks ping-pong: one is filled by blocks while the
//             other drains line by line through a 2-entry skid FIFO.
//  Ports    : clk - clock
//             rst - synchronous active-high reset
//             bus - block_to_raster_if.slave (input/output streams, err)
//  Revision : 1.0 - initial release
// ============================================================================
module block_to_raster #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  block_to_raster_if.slave  bus
);

  localparam int unsigned c_xw    = $clog2(WIDTH);
  localparam int unsigned c_aw    = c_xw + 3;
  localparam int unsigned c_depth = 2 ** c_aw;
  localparam int unsigned c_nblk  = WIDTH / 8;
  // WIDTH is a multiple of 8, so the block index is exactly c_xw-3 bits and
  // {blk, c} equals blk*8 + c.
  localparam int unsigned c_bw    = c_xw - 3;
  localparam int unsigned c_nband = HEIGHT / 8;
  localparam int unsigned c_bndw  = (c_nband > 1) ? $clog2(c_nband) : 1;

  localparam logic [c_bw-1:0]   c_blk_last  = c_bw'(c_nblk - 1);
  localparam logic [c_xw-1:0]   c_x_last    = c_xw'(WIDTH - 1);
  localparam logic [c_bndw-1:0] c_band_last = c_bndw'(c_nband - 1);

  typedef enum logic [0:0] {WR_BUF0 = 1'b0, WR_BUF1 = 1'b1} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_BUF0 = 2'd1, RD_BUF1 = 2'd2} rd_state_t;

  // ---------------------------------------------------------------- state
  wr_state_t         wr_state_q, wr_state_d;
  logic [2:0]        col_q, col_d;
  logic [2:0]        row_q, row_d;
  logic [c_bw-1:0]   blk_q, blk_d;
  logic [1:0]        full_q, full_d;
  logic              err_q, err_d;

  rd_state_t         rd_state_q, rd_state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [c_xw-1:0]   x_q, x_d;
  logic [2:0]        y_q, y_d;
  logic [c_bndw-1:0] band_q, band_d;
  logic              infl_q, infl_d;       // RAM read issued last cycle
  logic [3:0]        rd_flag_q, rd_flag_d; // {sof, eof, sol, eol} of that read

  logic [DATA_W-1:0] fifo_data_q [2];
  logic [DATA_W-1:0] fifo_data_d [2];
  logic [3:0]        fifo_flag_q [2];
  logic [3:0]        fifo_flag_d [2];
  logic              fifo_wp_q, fifo_wp_d;
  logic              fifo_rp_q, fifo_rp_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic [DATA_W-1:0] bank0_mem [c_depth];
  logic [DATA_W-1:0] bank1_mem [c_depth];
  logic [DATA_W-1:0] rd_data_q;

  // ---------------------------------------------------------------- wires
  logic              w_wr_bank;
  logic              w_in_fire;
  logic              w_wr_last;
  logic [c_aw-1:0]   w_wr_addr;
  logic              w_rd_go;
  logic              w_rd_last;
  logic              w_rd_sel;
  logic [c_aw-1:0]   w_rd_addr;
  logic [3:0]        w_rd_flags;
  logic              w_fifo_ne;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head_data;
  logic [3:0]        w_head_flag;
  logic              w_out_valid;

  // ---------------------------------------------------------------- write side
  assign w_wr_bank    = (wr_state_q == WR_BUF1);
  assign bus.in_ready = ~full_q[w_wr_bank];
  assign w_in_fire    = bus.in_valid & ~full_q[w_wr_bank];
  assign w_wr_last    = w_in_fire && (col_q == 3'd7) && (row_q == 3'd7) && (blk_q == c_blk_last);
  assign w_wr_addr    = {row_q, blk_q, col_q};

  // ---------------------------------------------------------------- read side
  assign w_rd_sel   = (rd_state_q == RD_BUF1);
  // Count the read in flight too, so the FIFO can never overflow.
  assign w_rd_go    = (rd_state_q != RD_IDLE) && ((fifo_cnt_q + {1'b0, infl_q}) < 2'd2);
  assign w_rd_last  = w_rd_go && (x_q == c_x_last) && (y_q == 3'd7);
  assign w_rd_addr  = {y_q, x_q};
  assign w_rd_flags = {(x_q == '0) && (y_q == 3'd0) && (band_q == '0),
                       (x_q == c_x_last) && (y_q == 3'd7) && (band_q == c_band_last),
                       (x_q == '0),
                       (x_q == c_x_last)};

  // ---------------------------------------------------------------- output
  // The RAM output register acts as a bypass in front of the FIFO: when the
  // FIFO is empty the fresh read is presented directly, otherwise it queues.
  assign w_fifo_ne   = (fifo_cnt_q != 2'd0);
  assign w_out_valid = w_fifo_ne | infl_q;
  assign w_head_data = w_fifo_ne ? fifo_data_q[fifo_rp_q] : rd_data_q;
  assign w_head_flag = w_fifo_ne ? fifo_flag_q[fifo_rp_q] : rd_flag_q;
  assign w_pop       = w_fifo_ne & bus.out_ready;
  assign w_push      = infl_q & ~(~w_fifo_ne & bus.out_ready);

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_head_data;
  assign bus.out_sof   = w_out_valid & w_head_flag[3];
  assign bus.out_eof   = w_out_valid & w_head_flag[2];
  assign bus.out_sol   = w_out_valid & w_head_flag[1];
  assign bus.out_eol   = w_out_valid & w_head_flag[0];
  assign bus.err       = err_q;

  // ---------------------------------------------------------------- next state
  always_comb begin
    wr_state_d  = wr_state_q;
    col_d       = col_q;
    row_d       = row_q;
    blk_d       = blk_q;
    full_d      = full_q;
    err_d       = err_q;
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    x_d         = x_q;
    y_d         = y_q;
    band_d      = band_q;
    infl_d      = w_rd_go;
    rd_flag_d   = rd_flag_q;
    fifo_data_d = fifo_data_q;
    fifo_flag_d = fifo_flag_q;
    fifo_wp_d   = fifo_wp_q;
    fifo_rp_d   = fifo_rp_q;
    fifo_cnt_d  = fifo_cnt_q + {1'b0, w_push} - {1'b0, w_pop};

    // Write counters: c, then r, then blk; framing errors never resync them.
    if (w_in_fire) begin
      col_d = col_q + 3'd1;
      if (col_q == 3'd7) begin
        row_d = row_q + 3'd1;
        if (row_q == 3'd7) begin
          blk_d = (blk_q == c_blk_last) ? '0 : blk_q + 1'b1;
        end
      end
      if ((bus.in_sop && ((col_q != 3'd0) || (row_q != 3'd0))) ||
          (bus.in_eop && ((col_q != 3'd7) || (row_q != 3'd7)))) begin
        err_d = 1'b1;
      end
    end

    if (w_wr_last) begin
      full_d[w_wr_bank] = 1'b1;
      wr_state_d        = w_wr_bank ? WR_BUF0 : WR_BUF1;
    end

    case (rd_state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_state_d = rd_bank_q ? RD_BUF1 : RD_BUF0;
        end
      end
      RD_BUF0, RD_BUF1: begin
        if (w_rd_last) begin
          rd_state_d = RD_IDLE;
          rd_bank_d  = ~rd_bank_q;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    if (w_rd_go) begin
      rd_flag_d = w_rd_flags;
      if (x_q == c_x_last) begin
        x_d = '0;
        y_d = y_q + 3'd1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    if (w_rd_last) begin
      full_d[w_rd_sel] = 1'b0;
      band_d = (band_q == c_band_last) ? '0 : band_q + 1'b1;
    end

    if (w_push) begin
      fifo_data_d[fifo_wp_q] = rd_data_q;
      fifo_flag_d[fifo_wp_q] = rd_flag_q;
      fifo_wp_d              = ~fifo_wp_q;
    end
    if (w_pop) begin
      fifo_rp_d = ~fifo_rp_q;
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q     <= WR_BUF0;
      col_q          <= '0;
      row_q          <= '0;
      blk_q          <= '0;
      full_q         <= '0;
      err_q          <= 1'b0;
      rd_state_q     <= RD_IDLE;
      rd_bank_q      <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      band_q         <= '0;
      infl_q         <= 1'b0;
      rd_flag_q      <= '0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_flag_q[0] <= '0;
      fifo_flag_q[1] <= '0;
      fifo_wp_q      <= 1'b0;
      fifo_rp_q      <= 1'b0;
      fifo_cnt_q     <= '0;
    end else begin
      wr_state_q     <= wr_state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      blk_q          <= blk_d;
      full_q         <= full_d;
      err_q          <= err_d;
      rd_state_q     <= rd_state_d;
      rd_bank_q      <= rd_bank_d;
      x_q            <= x_d;
      y_q            <= y_d;
      band_q         <= band_d;
      infl_q         <= infl_d;
      rd_flag_q      <= rd_flag_d;
      fifo_data_q    <= fifo_data_d;
      fifo_flag_q    <= fifo_flag_d;
      fifo_wp_q      <= fifo_wp_d;
      fifo_rp_q      <= fifo_rp_d;
      fifo_cnt_q     <= fifo_cnt_d;
    end
  end

  // Band storage; contents are don't-care after reset, validity lives in full_q.
  always_ff @(posedge clk) begin
    if (w_in_fire && !w_wr_bank) begin
      bank0_mem[w_wr_addr] <= bus.in_data;
    end
    if (w_in_fire && w_wr_bank) begin
      bank1_mem[w_wr_addr] <= bus.in_data;
    end
  end

  // One-cycle synchronous read; qualified by infl_q.
  always_ff @(posedge clk) begin
    if (w_rd_go) begin
      rd_data_q <= w_rd_sel ? bank1_mem[w_rd_addr] : bank0_mem[w_rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_to_raster.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_block_to_raster
//  Purpose  : Scoreboard bench for block_to_raster at WIDTH=16, HEIGHT=16.
//             Pixel value at (x,y) is (y*16+x)&0xFF, so a frame drains as
//             0..255; expected entries are {data, sol, eol, sof, eof}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_block_to_raster;

  localparam int W = 16;
  localparam int H = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  block_to_raster_if #(.DATA_W(8)) bus ();

  block_to_raster #(.WIDTH(W), .HEIGHT(H), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [11:0] exp_q [$];
  logic [11:0] mon_got;
  bit          toggle_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every presented pixel must equal the scoreboard head (this also
  // proves the output holds while stalled); pop only on an actual transfer.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      mon_got = {bus.out_data, bus.out_sol, bus.out_eol, bus.out_sof, bus.out_eof};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected actual=%h required=none at %0t", mon_got, $time);
      end else begin
        if (mon_got !== exp_q[0]) begin
          bad++;
          $display("FAIL out_pixel actual=%h required=%h at %0t", mon_got, exp_q[0], $time);
        end
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic sop, input logic eop);
    int   n;
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sop   = sop;
    bus.in_eop   = eop;
    n   = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 2000) begin
        total++;
        bad++;
        $display("FAIL in_accept_timeout actual=no_accept required=accept at %0t", $time);
        acc = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  // Expected raster for band b (0 or 1) of a 16x16 frame.
  task automatic push_band(input int b);
    logic [7:0] d;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < W; x++) begin
        d = 8'(((b * 8 + y) * W + x) & 255);
        exp_q.push_back({d, x == 0, x == W - 1, (b == 0) && (y == 0) && (x == 0),
                         (b == 1) && (y == 7) && (x == W - 1)});
      end
    end
  endtask

  // Feed nsamp samples of band b in block order.
  task automatic feed_part(input int b, input int nsamp);
    int cnt;
    cnt = 0;
    for (int k = 0; k < W / 8; k++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          if (cnt < nsamp) send(8'(((b * 8 + r) * W + k * 8 + c) & 255), (r == 0) && (c == 0),
                                (r == 7) && (c == 7));
          cnt++;
        end
      end
    end
  endtask

  task automatic feed_band(input int b);
    push_band(b);
    feed_part(b, 8 * W);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    repeat (4) @(negedge clk);
    chk({name, "_idle"}, bus.out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sop    = 1'b0;
    bus.in_eop    = 1'b0;
    bus.in_data   = '0;

    // ---- Test 1/2: reset state, latency, full frame in order
    do_reset();
    @(negedge clk);
    chk("rst_in_ready",  bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_err",       bus.err, 0);
    chk("rst_flags", {bus.out_sol, bus.out_eol, bus.out_sof, bus.out_eof}, 0);
    @(posedge clk); #1;
    feed_band(0);            // last sample accepted at the edge just passed
    @(negedge clk); chk("lat_t1_valid", bus.out_valid, 0);
    @(negedge clk); chk("lat_t2_valid", bus.out_valid, 0);
    @(negedge clk); chk("lat_t3_valid", bus.out_valid, 1);
    chk("lat_t3_data", bus.out_data, 0);
    chk("lat_t3_sol",  bus.out_sol, 1);
    chk("lat_t3_sof",  bus.out_sof, 1);
    @(posedge clk); #1;
    feed_band(1);
    drain("frame1_drain");

    // ---- Test 3: downstream stalled, both banks fill
    do_reset();
    bus.out_ready = 1'b0;
    feed_band(0);
    feed_band(1);
    repeat (3) @(negedge clk);
    chk("both_full_in_ready", bus.in_ready, 0);
    chk("stall_out_valid",    bus.out_valid, 1);
    chk("stall_out_data",     bus.out_data, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    feed_band(0);            // waits for bank 0 to drain
    drain("three_band_drain");

    // ---- Test 4: out_ready toggling
    do_reset();
    toggle_en = 1'b1;
    fork
      begin
        feed_band(0);
        feed_band(1);
        drain("toggle_drain");
        toggle_en = 1'b0;
      end
      begin
        while (toggle_en) begin
          @(posedge clk);
          #1 bus.out_ready = ~bus.out_ready;
        end
      end
    join
    bus.out_ready = 1'b1;

    // ---- Test 5: sticky framing error
    do_reset();
    send(8'd0, 1'b1, 1'b0);
    @(negedge clk); chk("err_good_sop", bus.err, 0);
    @(posedge clk); #1;
    send(8'd1, 1'b0, 1'b0);
    send(8'd2, 1'b1, 1'b0);
    @(negedge clk); chk("err_set", bus.err, 1);
    @(posedge clk); #1;
    send(8'd3, 1'b0, 1'b0);
    send(8'd4, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("err_sticky", bus.err, 1);
    do_reset();
    @(negedge clk); chk("err_cleared", bus.err, 0);
    @(posedge clk); #1;

    // ---- Test 6: reset in the middle of band 1
    do_reset();
    feed_band(0);
    feed_part(1, 64);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready",  bus.in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    feed_band(0);
    feed_band(1);
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
